// File: rtl/serial_pkg.sv
// Shared state encoding, default bit period and counter sizing for serial_uart.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} serial_state_e;

  localparam int DEFAULT_CLK_DIV = 1302;

  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/serial_uart_if.sv
// Console-side handshake bundle of serial_uart; master is the register block, slave is the UART.
interface serial_uart_if;

  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_read;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overflow;
  logic       err_clr;

  modport master (
    output tx_data, tx_send, rx_read, err_clr,
    input  tx_busy, rx_data, rx_ready, rx_frame_err, rx_parity_err, rx_overflow
  );

  modport slave (
    input  tx_data, tx_send, rx_read, err_clr,
    output tx_busy, rx_data, rx_ready, rx_frame_err, rx_parity_err, rx_overflow
  );

endinterface

// File: rtl/serial_fifo.sv
// Synchronous show-ahead FIFO; push on full is refused unless a pop happens in the same cycle.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/serial_uart.sv
// Full-duplex UART with start-glitch rejection, sticky error flags and a show-ahead RX FIFO.
// Defining SERIAL_PARITY_EN adds an even parity bit after the data bits in both directions.
module serial_uart
  import serial_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic          tx,
  serial_uart_if.slave  bus
);

  localparam int             CNT_W    = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  serial_state_e          tx_state, tx_state_next;
  logic [CNT_W-1:0]       tx_cnt;
  logic [2:0]             tx_idx;
  logic [DATA_BITS-1:0]   tx_shift;
  logic                   tx_line_next;
  logic                   tx_accept;
  logic                   tx_bit_end;
`ifdef SERIAL_PARITY_EN
  logic                   tx_par;
`endif

  assign tx_accept   = (tx_state == IDLE) && bus.tx_send;
  assign tx_bit_end  = (tx_cnt == CNT_LAST);
  assign bus.tx_busy = (tx_state != IDLE);

  // tx_line_next is the level the pin takes in the next cycle, so the pin itself is a flop.
  always_comb begin
    tx_state_next = tx_state;
    tx_line_next  = tx;
    case (tx_state)
      IDLE: begin
        tx_line_next = 1'b1;
        if (bus.tx_send) begin
          tx_state_next = START;
          tx_line_next  = 1'b0;
        end
      end
      START: if (tx_bit_end) begin
        tx_state_next = DATA;
        tx_line_next  = tx_shift[0];
      end
      DATA: if (tx_bit_end) begin
        if (tx_idx == BIT_LAST) begin
`ifdef SERIAL_PARITY_EN
          tx_state_next = PARITY;
          tx_line_next  = tx_par;
`else
          tx_state_next = STOP;
          tx_line_next  = 1'b1;
`endif
        end else begin
          tx_line_next = tx_shift[1];
        end
      end
      PARITY: if (tx_bit_end) begin
        tx_state_next = STOP;
        tx_line_next  = 1'b1;
      end
      STOP: if (tx_bit_end) begin
        tx_state_next = IDLE;
        tx_line_next  = 1'b1;
      end
      default: begin
        tx_state_next = IDLE;
        tx_line_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx       <= tx_line_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
`ifdef SERIAL_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_accept) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= bus.tx_data[DATA_BITS-1:0];
`ifdef SERIAL_PARITY_EN
      tx_par   <= ^bus.tx_data[DATA_BITS-1:0];
`endif
    end else if (tx_state != IDLE) begin
      tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
      if (tx_state == DATA && tx_bit_end) begin
        tx_shift <= tx_shift >> 1;
        tx_idx   <= tx_idx + 3'd1;
      end
    end
  end

  logic                   rx_meta, rx_sync, rx_prev;
  serial_state_e          rx_state, rx_state_next;
  logic [CNT_W-1:0]       rx_cnt;
  logic [2:0]             rx_idx;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_bit_end;
  logic                   rx_push;
  logic                   frame_set;
  logic                   overflow_set;
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_head;
  logic [7:0]             rx_word;
  logic                   frame_err, overflow_err;

  assign rx_bit_end = (rx_cnt == CNT_LAST);

  // rx_prev gives the 1->0 edge on the synchronised line; all three idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

`ifdef SERIAL_PARITY_EN
  logic parity_set;
  logic parity_err;
`endif

  always_comb begin
    rx_state_next = rx_state;
    rx_push       = 1'b0;
    frame_set     = 1'b0;
`ifdef SERIAL_PARITY_EN
    parity_set    = 1'b0;
`endif
    case (rx_state)
      IDLE:   if (rx_prev && !rx_sync) rx_state_next = START;
      START:  if (rx_cnt == CNT_HALF) rx_state_next = rx_sync ? IDLE : DATA;
      DATA: if (rx_bit_end && rx_idx == BIT_LAST) begin
`ifdef SERIAL_PARITY_EN
        rx_state_next = PARITY;
`else
        rx_state_next = STOP;
`endif
      end
      PARITY: if (rx_bit_end) begin
        rx_state_next = STOP;
`ifdef SERIAL_PARITY_EN
        parity_set    = rx_sync ^ (^rx_shift);
`endif
      end
      STOP: if (rx_bit_end) begin
        rx_state_next = IDLE;
        rx_push       = rx_sync;
        frame_set     = !rx_sync;
      end
      default: rx_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= IDLE;
    else        rx_state <= rx_state_next;
  end

  // Every state change restarts the bit timer so DATA samples land mid-bit after the half-bit START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == IDLE || rx_state_next != rx_state) rx_cnt <= '0;
      else rx_cnt <= rx_bit_end ? '0 : rx_cnt + CNT_W'(1);
      if (rx_state == IDLE) rx_idx <= '0;
      if (rx_state == DATA && rx_bit_end) begin
        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
    end
  end

  assign overflow_set = rx_push && fifo_full && !bus.rx_read;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      frame_err    <= frame_set    | (frame_err    & !bus.err_clr);
      overflow_err <= overflow_set | (overflow_err & !bus.err_clr);
    end
  end

`ifdef SERIAL_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= parity_set | (parity_err & !bus.err_clr);
  end
  assign bus.rx_parity_err = parity_err;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

  assign bus.rx_frame_err = frame_err;
  assign bus.rx_overflow  = overflow_err;

  serial_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (bus.rx_read),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    rx_word = '0;
    if (!fifo_empty) rx_word[DATA_BITS-1:0] = fifo_head;
  end

  assign bus.rx_data  = rx_word;
  assign bus.rx_ready = !fifo_empty;

endmodule

// File: doc/serial_uart.md
# serial_uart

Parametrised full-duplex UART for the vm1801mini system bus: configurable bit period, data width and receive FIFO depth, plus start-bit glitch rejection and error reporting. It replaces the separate fixed 38400-baud 8N1 receiver/transmitter pair. Instantiated between the board RX/TX pins and the console register interface. Optional even parity is selected at compile time.

## Interface
- CLK_DIV, 1302: clock cycles per bit (50 MHz / 38400); legal ≥ 8
- DATA_BITS, 8: data bits per frame, legal 5..8; unused upper bits of data ports are 0 / ignored
- FIFO_DEPTH, 4: RX FIFO entries, power of two ≥ 2

- clk  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; all state cleared immediately
- rx  in  1  serial input, asynchronous to clk, idle high
- tx  out  1  serial output, idle high
- tx_data  in  8  byte to send, sampled on accepted tx_send
- tx_send  in  1  one-cycle request; accepted only when tx_busy=0
- tx_busy  out  1  high from cycle after acceptance until stop bit ends
- rx_data  out  8  FIFO head (show-ahead); valid when rx_ready=1
- rx_ready  out  1  FIFO not empty
- rx_read  in  1  pop FIFO head; ignored when empty
- rx_frame_err  out  1  sticky: stop bit sampled 0
- rx_parity_err  out  1  sticky: parity mismatch (0 when parity compiled out)
- rx_overflow  out  1  sticky: byte dropped, FIFO full
- err_clr  in  1  one-cycle clear of all three sticky flags

## Operation
- Reset values: tx=1, tx_busy=0, rx_ready=0, rx_data=0, all error flags 0, both FSMs IDLE, FIFO empty.
- rx passes a 2-flop synchroniser (reset to 1); all RX timing below is from the synchronised signal.
- RX FSM: IDLE → START on synchronised 1→0. START: at count CLK_DIV/2 (integer) re-sample; 1 → IDLE (glitch, nothing recorded), 0 → DATA with counter restarted. DATA: sample each bit at CLK_DIV cycles, LSB first, DATA_BITS samples → PARITY (if enabled) else STOP. STOP: sample at CLK_DIV; 1 → push byte; 0 → set rx_frame_err, discard byte. Return to IDLE the same cycle; a new start edge is detectable on the next cycle.
- Push to full FIFO without simultaneous rx_read: byte discarded, rx_overflow set. Push+pop on full in one cycle: both succeed, no overflow. Pop+push on empty: push succeeds, rx_ready=1 next cycle.
- err_clr and a new error in the same cycle: flag ends set.
- TX FSM: IDLE → START on tx_send with tx_busy=0; tx_data latched. Sends start(0), DATA_BITS LSB first, parity (if enabled), one stop(1), each exactly CLK_DIV cycles. tx_send while busy is ignored.
- Bit counters: width $clog2(CLK_DIV); count 0..CLK_DIV-1, wrap to 0.

## Timing
- TX: tx falls in the cycle after accepted tx_send; tx_busy high same cycle. Frame length (1+DATA_BITS+P+1)·CLK_DIV cycles; tx_busy falls the cycle after the stop bit's last cycle, and a tx_send in that cycle is accepted (back-to-back frames, no idle gap).
- RX: rx_ready rises 1 cycle after the stop-bit sample; rx_data valid same cycle. rx_read pop takes effect next cycle (rx_ready/rx_data update).
- Sticky flags rise 1 cycle after the offending sample; clear 1 cycle after err_clr.

## Configuration
- SERIAL_PARITY_EN defined: even parity bit inserted after data on TX; checked on RX, mismatch sets rx_parity_err and byte is still pushed.
- Undefined: no parity bit in either direction, rx_parity_err tied 0, frame is 8N1-style (DATA_BITS + start + stop).

## Structure
- Package serial_pkg: RX/TX state enum (IDLE, START, DATA, PARITY, STOP), default CLK_DIV constant, counter-width function.
- Sub-module serial_fifo: synchronous show-ahead FIFO, parameters WIDTH, DEPTH; ports push/pop/full/empty/head. TX and RX FSMs stay in serial_uart.

## Test plan
- CLK_DIV=16, send 0xA5 → tx: 0, 1,0,1,0,0,1,0,1, 1, each 16 cycles; tx_busy high 160 cycles; rx loopback yields rx_data=0xA5, rx_ready=1.
- rx low pulse of 5 cycles (< CLK_DIV/2=8) → no start, rx_ready stays 0, no flags.
- Frame 0x3C with stop bit driven 0 → rx_frame_err=1, FIFO stays empty; err_clr → flag 0 next cycle.
- FIFO_DEPTH=4, five frames without rx_read → four bytes held in order, rx_overflow=1, fifth lost; four rx_read pulses drain, rx_ready=0.
- tx_send held on cycle busy drops → second frame's start bit immediately follows first stop bit; tx_send during busy ignored.
- SERIAL_PARITY_EN, send 0x07 → parity bit 1; inject wrong parity on rx → rx_parity_err=1, byte still delivered. Reset asserted mid-frame → tx=1, tx_busy=0, FIFO empty immediately.
